// File: rtl/axil_sr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_sr_bridge
// Brief    : 32-bit AXI-Lite OCL slave to 64-bit SoftReg request/response
//            bridge; optional read timeout under AXIL_SR_RD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================

package axil_sr_pkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;
endpackage

module axil_sr_bridge
    import axil_sr_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 1024,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output SoftRegReq   softreg_req,
    input  SoftRegResp  softreg_resp
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_RESP  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_lo_wr_buf;
    logic [31:0] r_hi_rd_buf;
    logic        r_hi_rd_vld;
    logic        r_bvalid;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    SoftRegReq   r_req;

    logic        w_wr_pair;
    logic        w_idle;
    logic        w_unused_ok;

`ifdef AXIL_SR_RD_TIMEOUT_EN
    localparam logic [31:0] c_timeout_last = 32'(RD_TIMEOUT - 1);
    logic [31:0] r_cnt;
    assign w_unused_ok = &{1'b0, wstrb, awaddr[1:0], araddr[1:0]};
`else
    assign w_unused_ok = &{1'b0, wstrb, awaddr[1:0], araddr[1:0], ERR_DATA, (RD_TIMEOUT != 0)};
`endif

    // AW and W are only ever taken together; a pending write pair blocks reads.
    assign w_wr_pair = awvalid && wvalid;
    assign w_idle    = (r_state == IDLE) && rst;
    assign awready   = w_idle && w_wr_pair;
    assign wready    = w_idle && w_wr_pair;
    assign arready   = w_idle && arvalid && !w_wr_pair;

    assign bvalid      = r_bvalid;
    assign bresp       = 2'b00;
    assign rvalid      = r_rvalid;
    assign rdata       = r_rdata;
    assign rresp       = r_rresp;
    assign softreg_req = r_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_lo_wr_buf <= '0;
            r_hi_rd_buf <= '0;
            r_hi_rd_vld <= 1'b0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= 2'b00;
            r_req       <= '0;
`ifdef AXIL_SR_RD_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_req.valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_wr_pair) begin
                        r_bvalid <= 1'b1;
                        r_state  <= WR_RESP;
                        if (awaddr[2]) begin
                            r_req <= {1'b1, 1'b1, {awaddr[31:3], 3'b000}, {wdata, r_lo_wr_buf}};
                        end else begin
                            r_lo_wr_buf <= wdata;
                        end
                    end else if (arvalid) begin
                        if (araddr[2]) begin
                            // Upper half comes from the last low-half read, consumed once.
                            r_rdata     <= r_hi_rd_vld ? r_hi_rd_buf : 32'h0;
                            r_rresp     <= 2'b00;
                            r_hi_rd_vld <= 1'b0;
                            r_rvalid    <= 1'b1;
                            r_state     <= RD_RESP;
                        end else begin
                            r_req   <= {1'b1, 1'b0, {araddr[31:3], 3'b000}, 64'h0};
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_state <= RD_WAIT;
`ifdef AXIL_SR_RD_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                RD_WAIT: begin
                    if (softreg_resp.valid) begin
                        r_rdata     <= softreg_resp.data[31:0];
                        r_hi_rd_buf <= softreg_resp.data[63:32];
                        r_hi_rd_vld <= 1'b1;
                        r_rresp     <= 2'b00;
                        r_rvalid    <= 1'b1;
                        r_state     <= RD_RESP;
                    end
`ifdef AXIL_SR_RD_TIMEOUT_EN
                    else if (r_cnt == c_timeout_last) begin
                        r_rdata     <= ERR_DATA;
                        r_rresp     <= 2'b10;
                        r_hi_rd_vld <= 1'b0;
                        r_rvalid    <= 1'b1;
                        r_state     <= RD_RESP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
`endif
                end
                WR_RESP: begin
                    if (bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/axil_sr_bridge.md
Name: axil_sr_bridge

Overview:
- Converts the shell's 32-bit AXI-Lite OCL slave port into the 64-bit SoftReg request/response stream.
- Sits directly upstream of the SoftReg splitter: its softreg_req/softreg_resp feed the splitter, which distributes them to per-app soft registers.
- Merges 32-bit AXI halves into 64-bit SoftReg accesses.
- Handles exactly one transaction at a time.

Parameters:
- RD_TIMEOUT, 1024, cycles to wait in RD_WAIT for softreg_resp.valid before failing the read (used only with the optional feature).
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a timed-out read.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- awvalid/awready  in/out  1  AXI-Lite write address handshake
- awaddr  in  32  write byte address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  32  write data
- wstrb  in  4  ignored; full-word writes only
- bvalid/bready  out/in  1  write response handshake
- bresp  out  2  always 2'b00
- arvalid/arready  in/out  1  read address handshake
- araddr  in  32  read byte address
- rvalid/rready  out/in  1  read data handshake
- rdata  out  32  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- softreg_req  out  SoftRegReq  {valid, isWrite, addr[31:0], data[63:0]} to splitter
- softreg_resp  in  SoftRegResp  {valid, data[63:0]} from splitter

Behaviour:
- Reset (rst low, asynchronous):
  - FSM enters IDLE.
  - All ready/valid outputs are 0; softreg_req is all-zero.
  - lo_wr_buf, hi_rd_buf and hi_rd_vld are cleared.
  - Timeout counter is 0.
- States and transitions:
  - IDLE -> WR_RESP: when awvalid && wvalid. awready=wready=1 for exactly that cycle, so AW and W are accepted jointly. AW without W, or W without AW, is not accepted.
  - IDLE -> RD_ISSUE or RD_RESP: when arvalid and no write pair is present. arready=1 for that cycle.
  - Simultaneous write pair and arvalid in IDLE: the write wins; the read waits.
- Write, awaddr[2]=0:
  - wdata goes to lo_wr_buf; no SoftReg request.
  - WR_RESP next cycle.
- Write, awaddr[2]=1:
  - On the cycle after acceptance, softreg_req.valid=1 for exactly one cycle with isWrite=1, addr={awaddr[31:3],3'b000}, data={wdata, lo_wr_buf}.
  - Enters WR_RESP in the same cycle.
  - lo_wr_buf is not cleared.
- WR_RESP: bvalid=1 and bresp=0 are held until bready, then IDLE. bready already high gives a 1-cycle response.
- Read, araddr[2]=0:
  - RD_ISSUE pulses softreg_req.valid=1 for one cycle with isWrite=0, addr aligned, data=0.
  - Then RD_WAIT.
  - On softreg_resp.valid: rdata=data[31:0], hi_rd_buf=data[63:32], hi_rd_vld=1, then RD_RESP.
  - Minimum latency from arvalid to rvalid is 3 cycles when the response arrives the cycle after the request.
- Read, araddr[2]=1:
  - No SoftReg request.
  - rdata=hi_rd_buf, rresp=OKAY, hi_rd_vld=0, then RD_RESP directly.
  - If hi_rd_vld=0: rdata=0, rresp=OKAY.
- RD_RESP: rvalid is held with stable rdata/rresp until rready, then IDLE.
- softreg_resp.valid outside RD_WAIT is ignored and dropped, with no state change.
- A reset mid-transaction abandons it: no bvalid/rvalid is produced and the buffers are cleared.
- Only one outstanding transaction exists at any time; arready/awready/wready are 0 outside IDLE.

Optional Feature:
- Macro: AXIL_SR_RD_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on entry to RD_WAIT and increments each RD_WAIT cycle.
  - On reaching RD_TIMEOUT with no response: rdata=ERR_DATA, rresp=2'b10, hi_rd_vld=0, RD_RESP.
  - A softreg_resp in the same cycle as the timeout wins and returns OKAY.
- When not defined: RD_WAIT waits indefinitely; rresp is always OKAY; no counter logic is present.

Test Plan:
- Write 0x11111111 @0x10, then 0x22222222 @0x14 -> exactly one softreg_req: isWrite=1, addr=0x10, data=0x22222222_11111111; two bvalid, both bresp=0.
- Read @0x20, splitter returns 0xAAAA_BBBB_CCCC_DDDD two cycles after the request -> rdata=0xCCCCDDDD; then read @0x24 -> rdata=0xAAAABBBB with no second softreg_req.
- awvalid, wvalid and arvalid asserted in the same cycle -> write is issued first, read is accepted only after bready completes; ordering is checked on softreg_req.
- bready/rready held low for 10 cycles -> bvalid/rvalid and rdata remain stable; no new AXI transaction is accepted.
- Stray softreg_resp.valid while IDLE -> no rvalid, state unchanged; the following read returns the correct data.
- With AXIL_SR_RD_TIMEOUT_EN and RD_TIMEOUT=16, no response -> rvalid 16 cycles after entering RD_WAIT with rdata=0xDEADBEEF and rresp=2'b10; a later read @0x24 returns 0.
